flag_ctrl: RTL and testbench
============================

Name: flag_ctrl

Overview:
- Owns the RAT CPU status flags C, Z and interrupt-enable I, plus a LIFO shadow stack of {C,Z} for nested interrupts.
- Sits between the ALU flag outputs and the control unit.
  - The control unit issues load, set and clear commands.
  - It issues save on interrupt entry and restore on RETIE/RETID.
- Replaces standalone per-flag registers; all flag state lives here.

Parameters:
DEPTH, 4, shadow stack entries (legal 1..8)
CNT_W, $clog2(DEPTH+1), width of the depth counter (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
C_IN  in  1  carry result from ALU
Z_IN  in  1  zero result from ALU
C_LD  in  1  load C from C_IN
Z_LD  in  1  load Z from Z_IN
C_SET  in  1  force C=1 (SEC)
C_CLR  in  1  force C=0 (CLC)
I_SET  in  1  enable interrupts (SEI)
I_CLR  in  1  disable interrupts (CLI)
FLG_SAVE  in  1  interrupt entry: push {C,Z}, clear I
FLG_RESTORE  in  1  return: pop {C,Z}
RESTORE_IE  in  1  with FLG_RESTORE: 1=RETIE (I<=1), 0=RETID (I<=0)
C_FLAG  out  1  registered carry flag
Z_FLAG  out  1  registered zero flag
I_FLAG  out  1  registered interrupt enable
SHAD_DEPTH  out  CNT_W  entries currently on shadow stack
SHAD_FULL  out  1  SHAD_DEPTH==DEPTH (combinational from count)
SHAD_EMPTY  out  1  SHAD_DEPTH==0 (combinational from count)

Behaviour:
- Reset (RST high, async): C_FLAG=0, Z_FLAG=0, I_FLAG=0, SHAD_DEPTH=0, all stack entries 0.
  - Reset mid-nesting discards all saved entries.
- All state updates at posedge clk. Outputs are register outputs, so a command in cycle N is visible after edge N (1-cycle latency).
- No command asserted: every flag holds its value. A deasserted load never clears a flag.
- Per-cycle priority, highest first: FLG_RESTORE, FLG_SAVE, then individual flag commands.
- FLG_RESTORE:
  - Not empty: C,Z <= top entry; depth decrements; I <= RESTORE_IE.
  - Empty: underflow. C,Z <= 0, depth stays 0, I <= RESTORE_IE.
  - Flag commands and FLG_SAVE in the same cycle are ignored.
- FLG_SAVE (no restore):
  - Not full: push current registered {C,Z} to slot[depth]; depth increments; I <= 0.
  - C,Z hold. C_LD, Z_LD, C_SET and C_CLR that cycle are ignored.
  - Full: overflow. No push, depth unchanged, I <= 0, C,Z hold.
- C update (no save/restore): C_SET > C_CLR > C_LD. C_SET and C_CLR both high gives C=1.
- Z update (no save/restore): Z_LD loads Z_IN, otherwise Z holds. Z_LD is independent of the C commands.
- I update (no save/restore): I_SET > I_CLR, otherwise I holds.
- Stack is strict LIFO. Wrap-around is impossible: depth saturates at 0 and DEPTH as above.
- SAVE and RESTORE together: restore wins; the save is dropped and counted as an error (see optional feature).

Optional Feature:
FLG_ERR_EN
- Defined: adds ports ERR (out, 1) and ERR_CLR (in, 1).
  - ERR is sticky and set at the edge after any of: overflow push, underflow pop, or simultaneous SAVE+RESTORE.
  - ERR clears on RST or ERR_CLR; set wins over clear in the same cycle.
- Undefined: those ports do not exist; the error conditions are silently handled exactly as in Behaviour.

Test Plan:
- Reset then idle 5 cycles -> C=Z=I=0, SHAD_DEPTH=0, SHAD_EMPTY=1; assert RST mid-cycle with depth=2 -> immediate clear, depth=0.
- C_IN=1,Z_IN=1,C_LD=Z_LD=1 one cycle, then all loads 0 for 3 cycles -> C=Z=1 held; C_SET=C_CLR=1 -> C=1; C_CLR alone -> C=0.
- C=1,Z=0,I=1; FLG_SAVE with C_LD=1,C_IN=0 -> depth=1, I=0, C stays 1; then Z_LD=1,Z_IN=1, C_CLR; FLG_RESTORE,RESTORE_IE=1 -> C=1,Z=0,I=1, depth=0.
- Nest DEPTH=4 saves with distinct {C,Z} = 01,10,11,00 -> SHAD_FULL=1; 5th save -> depth stays 4, ERR=1 (with FLG_ERR_EN); 4 restores return 00,11,10,01 in order.
- FLG_RESTORE,RESTORE_IE=0 with empty stack -> C=Z=0, I=0, depth=0, ERR=1; ERR_CLR -> ERR=0.
- Depth=1, FLG_SAVE+FLG_RESTORE same cycle -> pop performed, depth=0, ERR=1, no push.

Source files
------------

// File: rtl/flag_ctrl_if.sv
// flag_ctrl_if: control-unit/ALU to flag block signal bundle; ERR/ERR_CLR exist only with FLG_ERR_EN.
interface flag_ctrl_if #(parameter int DEPTH = 4);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLR, I_SET, I_CLR;
  logic FLG_SAVE, FLG_RESTORE, RESTORE_IE;
  logic C_FLAG, Z_FLAG, I_FLAG, SHAD_FULL, SHAD_EMPTY;
  logic [CNT_W-1:0] SHAD_DEPTH;
`ifdef FLG_ERR_EN
  logic ERR, ERR_CLR;
`endif
  modport master (
    output C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLR, I_SET, I_CLR, FLG_SAVE, FLG_RESTORE, RESTORE_IE,
`ifdef FLG_ERR_EN
    output ERR_CLR, input ERR,
`endif
    input C_FLAG, Z_FLAG, I_FLAG, SHAD_DEPTH, SHAD_FULL, SHAD_EMPTY
  );
  modport slave (
    input C_IN, Z_IN, C_LD, Z_LD, C_SET, C_CLR, I_SET, I_CLR, FLG_SAVE, FLG_RESTORE, RESTORE_IE,
`ifdef FLG_ERR_EN
    input ERR_CLR, output ERR,
`endif
    output C_FLAG, Z_FLAG, I_FLAG, SHAD_DEPTH, SHAD_FULL, SHAD_EMPTY
  );
endinterface

// File: rtl/flag_ctrl.sv
// flag_ctrl: RAT C/Z/I flags with a LIFO {C,Z} shadow stack for nested interrupts.
// Define FLG_ERR_EN to add the sticky ERR output and its ERR_CLR input.
module flag_ctrl #(parameter int DEPTH = 4) (
  input logic clk,
  input logic RST,
  flag_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic c_q, c_d, z_q, z_d, i_q, i_d, push;
  logic empty, full, restore, save;
  logic [CNT_W-1:0] depth_q, depth_d, top;
  // Sized to the full index range so the depth counter indexes it without truncation.
  logic [1:0] stk_q [2**CNT_W];
  assign empty = depth_q == '0;
  assign full = depth_q == CNT_W'(DEPTH);
  assign restore = bus.FLG_RESTORE;
  assign save = bus.FLG_SAVE & ~bus.FLG_RESTORE;
  assign top = depth_q - CNT_W'(1);
  always_comb begin
    c_d = bus.C_SET | (~bus.C_CLR & (bus.C_LD ? bus.C_IN : c_q));
    z_d = bus.Z_LD ? bus.Z_IN : z_q;
    i_d = bus.I_SET | (~bus.I_CLR & i_q);
    depth_d = depth_q;
    push = 1'b0;
    if (restore) begin
      c_d = ~empty & stk_q[top][1];
      z_d = ~empty & stk_q[top][0];
      i_d = bus.RESTORE_IE;
      depth_d = empty ? depth_q : top;
    end else if (save) begin
      c_d = c_q;
      z_d = z_q;
      i_d = 1'b0;
      push = ~full;
      depth_d = full ? depth_q : depth_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      i_q <= 1'b0;
      depth_q <= '0;
      for (int k = 0; k < 2**CNT_W; k++) stk_q[k] <= 2'b00;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      i_q <= i_d;
      depth_q <= depth_d;
      if (push) stk_q[depth_q] <= {c_q, z_q};
    end
  end
  assign bus.C_FLAG = c_q;
  assign bus.Z_FLAG = z_q;
  assign bus.I_FLAG = i_q;
  assign bus.SHAD_DEPTH = depth_q;
  assign bus.SHAD_FULL = full;
  assign bus.SHAD_EMPTY = empty;
`ifdef FLG_ERR_EN
  logic err_q, err_set;
  assign err_set = (restore & (empty | bus.FLG_SAVE)) | (save & full);
  always_ff @(posedge clk or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else err_q <= err_set | (err_q & ~bus.ERR_CLR);
  end
  assign bus.ERR = err_q;
`endif
endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: directed plus short random checks of flag_ctrl against a queue-based stack model.
module tb_flag_ctrl;
  localparam int DEPTH = 4;
  typedef struct {logic c, z, i, err; int depth;} exp_t;
  logic clk = 1'b0, RST = 1'b1;
  int tests = 0, fails = 0;
  logic mc, mz, mi, merr;
  logic [1:0] stk[$];
  exp_t sb[$];
  flag_ctrl_if #(.DEPTH(DEPTH)) bus ();
  flag_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .RST(RST), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic idle_in();
    {bus.C_IN, bus.Z_IN, bus.C_LD, bus.Z_LD, bus.C_SET, bus.C_CLR} = '0;
    {bus.I_SET, bus.I_CLR, bus.FLG_SAVE, bus.FLG_RESTORE, bus.RESTORE_IE} = '0;
`ifdef FLG_ERR_EN
    bus.ERR_CLR = 1'b0;
`endif
  endtask
  function automatic exp_t snap();
    exp_t e;
    e.c = mc; e.z = mz; e.i = mi; e.err = merr; e.depth = stk.size();
    return e;
  endfunction
  task automatic cmp(string tag, exp_t e);
    chk({tag, ".C"}, int'(bus.C_FLAG), int'(e.c));
    chk({tag, ".Z"}, int'(bus.Z_FLAG), int'(e.z));
    chk({tag, ".I"}, int'(bus.I_FLAG), int'(e.i));
    chk({tag, ".depth"}, int'(bus.SHAD_DEPTH), e.depth);
    chk({tag, ".full"}, int'(bus.SHAD_FULL), int'(e.depth == DEPTH));
    chk({tag, ".empty"}, int'(bus.SHAD_EMPTY), int'(e.depth == 0));
`ifdef FLG_ERR_EN
    chk({tag, ".err"}, int'(bus.ERR), int'(e.err));
`endif
  endtask
  task automatic model_reset();
    mc = 0; mz = 0; mi = 0; merr = 0;
    stk.delete();
  endtask
  task automatic model_step();
    logic eset = 0;
    if (bus.FLG_RESTORE) begin
      if (stk.size() > 0) {mc, mz} = stk.pop_back();
      else begin mc = 0; mz = 0; eset = 1; end
      mi = bus.RESTORE_IE;
      if (bus.FLG_SAVE) eset = 1;
    end else if (bus.FLG_SAVE) begin
      if (stk.size() < DEPTH) stk.push_back({mc, mz});
      else eset = 1;
      mi = 0;
    end else begin
      if (bus.C_SET) mc = 1;
      else if (bus.C_CLR) mc = 0;
      else if (bus.C_LD) mc = bus.C_IN;
      if (bus.Z_LD) mz = bus.Z_IN;
      if (bus.I_SET) mi = 1;
      else if (bus.I_CLR) mi = 0;
    end
`ifdef FLG_ERR_EN
    if (eset) merr = 1;
    else if (bus.ERR_CLR) merr = 0;
`endif
  endtask
  task automatic cyc(string tag);
    model_step();
    sb.push_back(snap());
    @(posedge clk);
    #1;
    cmp(tag, sb.pop_front());
    idle_in();
  endtask
  initial begin
    idle_in();
    model_reset();
    @(posedge clk);
    #1;
    cmp("reset", snap());
    RST = 1'b0;
    repeat (5) cyc("idle");
    bus.C_IN = 1; bus.Z_IN = 1; bus.C_LD = 1; bus.Z_LD = 1; cyc("load11");
    repeat (3) cyc("hold");
    bus.C_SET = 1; bus.C_CLR = 1; cyc("set_clr");
    bus.C_CLR = 1; cyc("clr");
    bus.C_SET = 1; bus.Z_LD = 1; bus.Z_IN = 0; bus.I_SET = 1; cyc("prep");
    bus.FLG_SAVE = 1; bus.C_LD = 1; bus.C_IN = 0; cyc("save_ld");
    bus.Z_LD = 1; bus.Z_IN = 1; bus.C_CLR = 1; cyc("isr_body");
    bus.FLG_RESTORE = 1; bus.RESTORE_IE = 1; cyc("retie");
    for (int n = 0; n < DEPTH; n++) begin
      logic [1:0] p;
      p = 2'(n + 1);
      bus.C_LD = 1; bus.Z_LD = 1; bus.C_IN = p[1]; bus.Z_IN = p[0]; cyc("nest_ld");
      bus.FLG_SAVE = 1; cyc("nest_save");
    end
    bus.FLG_SAVE = 1; cyc("overflow");
    for (int n = 0; n < DEPTH; n++) begin
      bus.FLG_RESTORE = 1; bus.RESTORE_IE = 1; cyc("unnest");
    end
    bus.FLG_RESTORE = 1; bus.RESTORE_IE = 0; cyc("underflow");
`ifdef FLG_ERR_EN
    bus.ERR_CLR = 1; cyc("err_clr");
`endif
    bus.C_SET = 1; bus.Z_LD = 1; bus.Z_IN = 1; cyc("prep2");
    bus.FLG_SAVE = 1; cyc("save1");
    bus.FLG_SAVE = 1; bus.FLG_RESTORE = 1; bus.RESTORE_IE = 1; cyc("save_restore");
`ifdef FLG_ERR_EN
    bus.ERR_CLR = 1; cyc("err_clr2");
`endif
    for (int n = 0; n < 60; n++) begin
      bus.C_IN = 1'($urandom); bus.Z_IN = 1'($urandom);
      bus.C_LD = 1'($urandom); bus.Z_LD = 1'($urandom);
      bus.C_SET = ($urandom_range(0, 3) == 0); bus.C_CLR = ($urandom_range(0, 3) == 0);
      bus.I_SET = 1'($urandom); bus.I_CLR = 1'($urandom);
      bus.FLG_SAVE = ($urandom_range(0, 2) == 0); bus.FLG_RESTORE = ($urandom_range(0, 3) == 0);
      bus.RESTORE_IE = 1'($urandom);
`ifdef FLG_ERR_EN
      bus.ERR_CLR = ($urandom_range(0, 3) == 0);
`endif
      cyc("rand");
    end
    bus.C_SET = 1; cyc("prep3");
    bus.FLG_SAVE = 1; cyc("mid_save1");
    bus.FLG_SAVE = 1; cyc("mid_save2");
    @(negedge clk);
    RST = 1'b1;
    #1;
    model_reset();
    cmp("async_rst", snap());
    @(negedge clk);
    RST = 1'b0;
    cyc("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
